mul_seq: RTL
============

MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 Parameter XLEN, default 32, operand and result width in bits.
REQ-002 Parameter CNT_W, default 5, iteration counter width; XLEN equals 2^CNT_W.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 mul_trigger  input  1  multiply request from decode.
REQ-006 mul_type  input  2  0=muli, 1=mulr, 2=mulsi, 3=mulsr.
REQ-007 dest_reg  input  4  destination register of the multiply.
REQ-008 rs1_data  input  XLEN  first operand value, read via source-first register.
REQ-009 rs2_data  input  XLEN  second operand value, used for types 1 and 3.
REQ-010 imm  input  16  immediate second operand, used for types 0 and 2.
REQ-011 flush  input  1  abort of the in-flight multiply.
REQ-012 stall  output  1  freezes fetch/decode while the multiply runs.
REQ-013 busy  output  1  sequencer is not IDLE.
REQ-014 result_valid  output  1  one-cycle pulse; result is ready for writeback.
REQ-015 result  output  XLEN  low XLEN bits of the product.
REQ-016 result_dest  output  4  writeback register, paired with result_valid.
REQ-017 overflow  output  1  product does not fit in XLEN bits (signed or unsigned, per type).

Function
REQ-018 States: IDLE, RUN, DONE; encoding is free.
REQ-019 In IDLE, mul_trigger=1 and flush=0 at an edge latch operands and dest_reg, clear counter/accumulator, and go to RUN.
REQ-020 Operand B: types 0/2 use imm (type 0 zero-extended, type 2 sign-extended); types 1/3 use rs2_data.
REQ-021 Types 2/3 treat A and B as two's complement; latch magnitudes |A|, |B| and a sign = sign(A) xor sign(B); types 0/1 give sign=0.
REQ-022 RUN: each edge processes multiplier bit counter of |B|; if set, add |A| shifted by counter into a 2*XLEN accumulator; counter increments.
REQ-023 RUN lasts exactly XLEN edges, regardless of operand values; zero operands do not exit early.
REQ-024 After XLEN RUN edges, go to DONE with the final product (negated in 2*XLEN bits when sign=1) registered.
REQ-025 DONE lasts one cycle: result_valid=1, result=product[XLEN-1:0], result_dest=latched dest_reg; next edge goes to IDLE.
REQ-026 overflow, valid only with result_valid: unsigned = product[2*XLEN-1:XLEN] != 0; signed = upper XLEN+1 bits are not all equal.
REQ-027 Latency: trigger sampled at edge k -> result_valid high in the cycle after edge k+XLEN+1, i.e. XLEN+1 cycles after capture.
REQ-028 stall = (IDLE and mul_trigger) or RUN, combinational; stall=0 in DONE, so decode advances the cycle writeback occurs.
REQ-029 mul_trigger is ignored in RUN and DONE; a trigger held through DONE does not start a second multiply.
REQ-030 busy=1 in RUN and DONE.
REQ-031 flush=1 at any edge forces IDLE, no result_valid; flush and trigger together in IDLE do not start a multiply.
REQ-032 Most-negative operand (e.g. 0x80000000) in signed modes uses magnitude 2^(XLEN-1) as unsigned; the product stays correct.

Reset
REQ-033 rst=1 at an edge forces IDLE, counter=0, accumulator=0, result=0, result_dest=0, overflow=0; outputs stall, busy and result_valid are 0 after that edge.
REQ-034 rst takes priority over flush and mul_trigger; rst mid-RUN discards the operation and no result_valid follows.

Verification
REQ-035 muli, rs1=7, imm=0x0006, dest=3 -> after 33 cycles result_valid one cycle, result=42, result_dest=3, overflow=0.
REQ-036 mulsr, rs1=0xFFFFFFFD (-3), rs2=5 -> result=0xFFFFFFF1 (-15), overflow=0; mulsi, rs1=-3, imm=0xFFFE -> result=6.
REQ-037 mulr, rs1=0x10000, rs2=0x10000 -> result=0, overflow=1; mulsr, 0x80000000 x 0xFFFFFFFF -> result=0x80000000, overflow=1.
REQ-038 mul_trigger held high through DONE and the following IDLE cycle -> a new multiply starts only on the IDLE edge; stall is 0 in DONE.
REQ-039 Reset or flush asserted at RUN cycle 10 -> IDLE next edge, no result_valid for 40 cycles, and a new trigger completes normally.

Source files
------------

// File: rtl/mul_seq_if.sv
// Request/result bundle between decode and the sequential multiplier.
// Decode drives the request side; the multiplier returns stall, status and writeback data.
interface mul_seq_if #(
    parameter int unsigned XLEN = 32
);
    logic            mul_trigger;
    logic [1:0]      mul_type;
    logic [3:0]      dest_reg;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [15:0]     imm;
    logic            flush;
    logic            stall;
    logic            busy;
    logic            result_valid;
    logic [XLEN-1:0] result;
    logic [3:0]      result_dest;
    logic            overflow;

    modport master (
        output mul_trigger, mul_type, dest_reg, rs1_data, rs2_data, imm, flush,
        input  stall, busy, result_valid, result, result_dest, overflow
    );

    modport slave (
        input  mul_trigger, mul_type, dest_reg, rs1_data, rs2_data, imm, flush,
        output stall, busy, result_valid, result, result_dest, overflow
    );
endinterface

// File: rtl/mul_seq.sv
// Sequential shift-and-add multiplier: one multiplier bit per cycle on operand magnitudes,
// sign applied once at the end; one-cycle result pulse with overflow flag.
module mul_seq #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic     clk,
    input  logic     rst,
    mul_seq_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                fin_q, fin_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     a_mag_q, a_mag_d;
    logic [XLEN-1:0]     b_mag_q, b_mag_d;
    logic                sign_q, sign_d;
    logic                signed_q, signed_d;
    logic [3:0]          dest_q, dest_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic [3:0]          rdest_q, rdest_d;
    logic                ovf_q, ovf_d;

    logic [XLEN-1:0]     op_b;
    logic                is_signed, a_neg, b_neg;
    logic [2*XLEN-1:0]   partial, prod;
    logic                prod_ovf;

    // Operand B selection and magnitude extraction for the capture edge.
    always_comb begin
        is_signed = bus.mul_type[1];
        if (bus.mul_type[0]) begin
            op_b = bus.rs2_data;
        end else if (bus.mul_type[1]) begin
            op_b = {{(XLEN-16){bus.imm[15]}}, bus.imm};
        end else begin
            op_b = {{(XLEN-16){1'b0}}, bus.imm};
        end
        a_neg = is_signed & bus.rs1_data[XLEN-1];
        b_neg = is_signed & op_b[XLEN-1];
    end

    // The most-negative value negates to itself, which read unsigned is the correct magnitude.
    always_comb begin
        partial  = {{XLEN{1'b0}}, a_mag_q} << cnt_q;
        prod     = sign_q ? ({(2*XLEN){1'b0}} - acc_q) : acc_q;
        if (signed_q) begin
            prod_ovf = !((&prod[2*XLEN-1:XLEN-1]) | ~(|prod[2*XLEN-1:XLEN-1]));
        end else begin
            prod_ovf = |prod[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fin_d    = fin_q;
        acc_d    = acc_q;
        a_mag_d  = a_mag_q;
        b_mag_d  = b_mag_q;
        sign_d   = sign_q;
        signed_d = signed_q;
        dest_d   = dest_q;
        result_d = result_q;
        rdest_d  = rdest_q;
        ovf_d    = ovf_q;

        if (bus.flush) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.mul_trigger) begin
                        state_d  = StRun;
                        cnt_d    = '0;
                        fin_d    = 1'b0;
                        acc_d    = '0;
                        a_mag_d  = a_neg ? (~bus.rs1_data + 1'b1) : bus.rs1_data;
                        b_mag_d  = b_neg ? (~op_b + 1'b1) : op_b;
                        sign_d   = a_neg ^ b_neg;
                        signed_d = is_signed;
                        dest_d   = bus.dest_reg;
                    end
                end
                StRun: begin
                    // XLEN bit-steps, then one extra edge to register the signed product.
                    if (fin_q) begin
                        state_d  = StDone;
                        fin_d    = 1'b0;
                        result_d = prod[XLEN-1:0];
                        rdest_d  = dest_q;
                        ovf_d    = prod_ovf;
                    end else begin
                        if (b_mag_q[cnt_q]) begin
                            acc_d = acc_q + partial;
                        end
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(XLEN - 1)) begin
                            fin_d = 1'b1;
                        end
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            fin_q    <= 1'b0;
            acc_q    <= '0;
            a_mag_q  <= '0;
            b_mag_q  <= '0;
            sign_q   <= 1'b0;
            signed_q <= 1'b0;
            dest_q   <= '0;
            result_q <= '0;
            rdest_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            fin_q    <= fin_d;
            acc_q    <= acc_d;
            a_mag_q  <= a_mag_d;
            b_mag_q  <= b_mag_d;
            sign_q   <= sign_d;
            signed_q <= signed_d;
            dest_q   <= dest_d;
            result_q <= result_d;
            rdest_q  <= rdest_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.stall        = ((state_q == StIdle) & bus.mul_trigger) | (state_q == StRun);
    assign bus.busy         = (state_q != StIdle);
    assign bus.result_valid = (state_q == StDone);
    assign bus.result       = result_q;
    assign bus.result_dest  = rdest_q;
    assign bus.overflow     = ovf_q;

endmodule
